// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Captures each completed UART receive byte once and buffers it
//             in a first-word-fall-through FIFO with occupancy and overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

    generate
        if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
            $error("uart_rx_fifo: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    logic [7:0]        mem_q [DEPTH];
    logic              done_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic w_push;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == c_depth);
    assign m_valid  = ~empty;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign m_data   = empty ? 8'h00 : mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_push   = rx_done & ~done_q;
    assign w_pop    = m_valid & m_ready;
    assign w_accept = w_push & (~full | w_pop);
    assign w_drop   = w_push & full & ~w_pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({w_accept, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
        // Set has priority over clear so a drop is never lost.
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // The edge detector keeps tracking during reset so a held level is not seen as new.
    always_ff @(posedge clk) begin
        done_q <= rx_done;
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Directed self-checking bench for uart_rx_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;

    int vectors;
    int miscompares;

    uart_rx_fifo #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", m_valid); end
        vectors++; if (m_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", m_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
    endtask

    task automatic test_single_byte();
        rx_data = 8'hA5;
        rx_done = 1'b1;
        tick();
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", m_valid); end
        vectors++; if (m_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h want a5", m_data); end
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", count); end
        repeat (51) tick();
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL single_once got %0d want 1", count); end
        rx_done = 1'b0;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL single_pop_empty got %b want 1", empty); end
        vectors++; if (m_data !== 8'h00) begin miscompares++; $display("FAIL single_pop_data got %h want 00", m_data); end
        tick();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL single_idle_ready got %0d want 0", count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 3);
            if (i == 15) begin
                vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b want 1", full); end
                vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_count got %0d want 16", count); end
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fill_ovf_early got %b want 0", overflow); end
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fill_ovf got %b want 1", overflow); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_drop_count got %0d want 16", count); end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++; if (m_data !== 8'(i)) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", i, m_data, 8'(i)); end
            tick();
        end
        m_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b want 1", empty); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 2);
        rx_data = 8'hEE;
        rx_done = 1'b1;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL simul_count got %0d want 16", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL simul_ovf got %b want 0", overflow); end
        vectors++; if (m_data !== 8'h21) begin miscompares++; $display("FAIL simul_head got %h want 21", m_data); end
        rx_done = 1'b0;
        tick();
        m_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            vectors++;
            if (m_data !== ((i == 16) ? 8'hEE : 8'h20 + 8'(i))) begin
                miscompares++;
                $display("FAIL simul_drain[%0d] got %h want %h", i, m_data, (i == 16) ? 8'hEE : 8'h20 + 8'(i));
            end
            tick();
        end
        m_ready = 1'b0;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL simul_end_count got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic       prev_done;
        logic       popped;
        int         rcvd;
        int         cyc;
        rcvd = 0;
        prev_done = 1'b0;
        cyc = 0;
        // 40 bytes, each 3 cycles high then 2 low, consumer ready at random.
        while (cyc < 40 * 5 + 80) begin
            if (cyc < 200) begin
                rx_done = ((cyc % 5) < 3);
                rx_data = 8'((cyc / 5) * 7 + 3);
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                rx_done = 1'b0;
                m_ready = 1'b1;
            end
            vectors++; if (m_valid !== (q.size() != 0)) begin miscompares++; $display("FAIL wrap_valid cyc %0d got %b want %b", cyc, m_valid, q.size() != 0); end
            popped = 1'b0;
            if (m_valid && m_ready && q.size() != 0) begin
                vectors++; if (m_data !== q[0]) begin miscompares++; $display("FAIL wrap_data[%0d] got %h want %h", rcvd, m_data, q[0]); end
                void'(q.pop_front());
                popped = 1'b1;
                rcvd++;
            end
            if (rx_done && !prev_done && (q.size() < 16 || popped)) q.push_back(rx_data);
            prev_done = rx_done;
            tick();
            cyc++;
            if (cyc >= 200 && q.size() == 0 && empty) break;
        end
        m_ready = 1'b0;
        vectors++; if (rcvd !== 40) begin miscompares++; $display("FAIL wrap_received got %0d want 40", rcvd); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL wrap_count got %0d want 0", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf got %b want 0", overflow); end
    endtask

    task automatic test_set_clear_collision();
        for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i), 2);
        rx_data = 8'hDD;
        rx_done = 1'b1;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL collide_ovf got %b want 1", overflow); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL collide_count got %0d want 16", count); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL collide_clear got %b want 0", overflow); end
        rx_done = 1'b0;
        tick();
        vectors++; if (m_data !== 8'h50) begin miscompares++; $display("FAIL collide_head got %h want 50", m_data); end
    endtask

    task automatic test_reset_midop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i), 2);
        vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL rst_pre_count got %0d want 5", count); end
        rst = 1'b1;
        rx_data = 8'h77;
        rx_done = 1'b1;
        tick();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", count); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", m_valid); end
        rst = 1'b0;
        repeat (3) tick();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rst_held_count got %0d want 0", count); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_held_valid got %b want 0", m_valid); end
        rx_done = 1'b0;
        tick();
        send_byte(8'h3C, 4);
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL rst_fresh_count got %0d want 1", count); end
        vectors++; if (m_data !== 8'h3C) begin miscompares++; $display("FAIL rst_fresh_data got %h want 3c", m_data); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_simul_full();
        test_wrap();
        test_set_clear_collision();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
